// File: rtl/sudoku_game_ctrl.sv
// Sudoku game control: title page, difficulty selection, grid draw and play loop,
// with PS/2 key decode, N x N cursor and a one-outstanding draw_req/draw_done handshake.
// Optional: define CURSOR_WRAP_EN to make the cursor wrap at grid edges instead of saturating.
//
// Handshake: draw_req rises the cycle after a *_REQ state is entered and stays high,
// with draw_kind/digit/origin/cursor stable, until draw_done is sampled high; draw_done
// seen while draw_req is low is ignored.
module sudoku_game_ctrl #(
    parameter int GRID_N    = 9,
    parameter int CELL_PX   = 11,
    parameter int X0        = 0,
    parameter int Y0        = 0,
    parameter int NUM_MODES = 2,
    parameter int MODE_W    = 1,
    parameter int RC_W      = 4
) (
    input  logic              clock,
    input  logic              end_game,
    input  logic              start,
    input  logic              mode_go,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic [7:0]        scan_code,
    input  logic              scan_valid,
    input  logic              draw_done,
    output logic              draw_req,
    output logic [1:0]        draw_kind,
    output logic [MODE_W-1:0] grid_mode,
    output logic [RC_W-1:0]   cursor_row,
    output logic [RC_W-1:0]   cursor_col,
    output logic [3:0]        digit,
    output logic [7:0]        x_origin,
    output logic [6:0]        y_origin,
    output logic              key_overrun
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PAGE_REQ   = 3'd1,
        S_SELECT     = 3'd2,
        S_GRID_REQ   = 3'd3,
        S_CURSOR_REQ = 3'd4,
        S_PLAY       = 3'd5,
        S_DIGIT_REQ  = 3'd6
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [31:0]     GRID_N_L    = GRID_N;
    localparam logic [31:0]     NUM_MODES_L = NUM_MODES;
    localparam logic [RC_W-1:0] LAST_RC     = RC_W'(GRID_N - 1);

    state_t state, state_next;

    // Scancode decode
    logic       brk_flag;
    logic       dec_hit;
    logic       dec_arrow;
    logic [3:0] dec_val;
    logic       live_ev;

    // Pending key slot and event arbitration
    logic       armed;
    logic       pend_v;
    logic       pend_arrow;
    logic [3:0] pend_val;
    logic       act_v;
    logic       act_arrow;
    logic [3:0] act_val;
    logic       take_ev;

    logic       is_req_state;
    logic       done_hit;
    logic       mode_ok;

    always_comb begin
        dec_hit   = 1'b0;
        dec_arrow = 1'b0;
        dec_val   = 4'd0;
        case (scan_code)
            8'h16: begin dec_hit = 1'b1; dec_val = 4'd1; end
            8'h1E: begin dec_hit = 1'b1; dec_val = 4'd2; end
            8'h26: begin dec_hit = 1'b1; dec_val = 4'd3; end
            8'h25: begin dec_hit = 1'b1; dec_val = 4'd4; end
            8'h2E: begin dec_hit = 1'b1; dec_val = 4'd5; end
            8'h36: begin dec_hit = 1'b1; dec_val = 4'd6; end
            8'h3D: begin dec_hit = 1'b1; dec_val = 4'd7; end
            8'h3E: begin dec_hit = 1'b1; dec_val = 4'd8; end
            8'h46: begin dec_hit = 1'b1; dec_val = 4'd9; end
            8'h45, 8'h66: begin dec_hit = 1'b1; dec_val = 4'd0; end
            8'h75: begin dec_hit = 1'b1; dec_arrow = 1'b1; dec_val = {2'b00, DIR_UP};    end
            8'h72: begin dec_hit = 1'b1; dec_arrow = 1'b1; dec_val = {2'b00, DIR_DOWN};  end
            8'h6B: begin dec_hit = 1'b1; dec_arrow = 1'b1; dec_val = {2'b00, DIR_LEFT};  end
            8'h74: begin dec_hit = 1'b1; dec_arrow = 1'b1; dec_val = {2'b00, DIR_RIGHT}; end
            default: ;
        endcase
    end

    // A digit beyond the grid size is not a legal value and produces no event.
    assign live_ev = scan_valid && !brk_flag && dec_hit &&
                     (dec_arrow || (32'(dec_val) <= GRID_N_L));

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game) begin
            brk_flag <= 1'b0;
        end else if (scan_valid) begin
            if (brk_flag)
                brk_flag <= 1'b0;
            else if (scan_code == 8'hF0)
                brk_flag <= 1'b1;
        end
    end

    // The buffered event always takes priority so keys are executed in arrival order.
    assign act_v     = pend_v || live_ev;
    assign act_arrow = pend_v ? pend_arrow : dec_arrow;
    assign act_val   = pend_v ? pend_val   : dec_val;

    assign is_req_state = (state == S_PAGE_REQ) || (state == S_GRID_REQ) ||
                          (state == S_CURSOR_REQ) || (state == S_DIGIT_REQ);
    assign done_hit     = draw_req && draw_done;
    assign mode_ok      = (32'(mode_sel) < NUM_MODES_L);

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_ev    = 1'b0;
        draw_kind  = 2'd0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_PAGE_REQ;
            end
            S_PAGE_REQ: begin
                draw_kind = 2'd0;
                if (done_hit)
                    state_next = S_SELECT;
            end
            S_SELECT: begin
                if (mode_go && mode_ok)
                    state_next = S_GRID_REQ;
            end
            S_GRID_REQ: begin
                draw_kind = 2'd1;
                if (done_hit)
                    state_next = S_CURSOR_REQ;
            end
            S_CURSOR_REQ: begin
                draw_kind = 2'd3;
                if (done_hit)
                    state_next = S_PLAY;
            end
            S_PLAY: begin
                if (act_v) begin
                    take_ev    = 1'b1;
                    state_next = act_arrow ? S_CURSOR_REQ : S_DIGIT_REQ;
                end
            end
            S_DIGIT_REQ: begin
                draw_kind = 2'd2;
                if (done_hit)
                    state_next = S_PLAY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game)
            draw_req <= 1'b0;
        else
            draw_req <= is_req_state && !done_hit;
    end

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game)
            grid_mode <= '0;
        else if ((state == S_SELECT) && mode_go && mode_ok)
            grid_mode <= mode_sel;
    end

    // Keys only count once the playfield is on screen for the first time.
    always_ff @(posedge clock or posedge end_game) begin
        if (end_game)
            armed <= 1'b0;
        else if ((state == S_CURSOR_REQ) && done_hit)
            armed <= 1'b1;
    end

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game) begin
            pend_v      <= 1'b0;
            pend_arrow  <= 1'b0;
            pend_val    <= 4'd0;
            key_overrun <= 1'b0;
        end else if (state == S_PLAY) begin
            // Slot drains this cycle; a key arriving alongside a buffered one takes its place.
            pend_v <= pend_v && live_ev;
            if (pend_v && live_ev) begin
                pend_arrow <= dec_arrow;
                pend_val   <= dec_val;
            end
        end else if (armed && live_ev) begin
            if (!pend_v) begin
                pend_v     <= 1'b1;
                pend_arrow <= dec_arrow;
                pend_val   <= dec_val;
            end else begin
                key_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game)
            digit <= 4'd0;
        else if (take_ev && !act_arrow)
            digit <= act_val;
    end

    always_ff @(posedge clock or posedge end_game) begin
        if (end_game) begin
            cursor_row <= '0;
            cursor_col <= '0;
        end else if (take_ev && act_arrow) begin
            case (act_val[1:0])
                DIR_UP: begin
                    if (cursor_row != '0)
                        cursor_row <= cursor_row - 1'b1;
`ifdef CURSOR_WRAP_EN
                    else
                        cursor_row <= LAST_RC;
`endif
                end
                DIR_DOWN: begin
                    if (cursor_row != LAST_RC)
                        cursor_row <= cursor_row + 1'b1;
`ifdef CURSOR_WRAP_EN
                    else
                        cursor_row <= '0;
`endif
                end
                DIR_LEFT: begin
                    if (cursor_col != '0)
                        cursor_col <= cursor_col - 1'b1;
`ifdef CURSOR_WRAP_EN
                    else
                        cursor_col <= LAST_RC;
`endif
                end
                default: begin
                    if (cursor_col != LAST_RC)
                        cursor_col <= cursor_col + 1'b1;
`ifdef CURSOR_WRAP_EN
                    else
                        cursor_col <= '0;
`endif
                end
            endcase
        end
    end

    // Modular 8/7-bit arithmetic gives the required truncation directly.
    always_ff @(posedge clock or posedge end_game) begin
        if (end_game) begin
            x_origin <= 8'd0;
            y_origin <= 7'd0;
        end else begin
            x_origin <= 8'(X0) + 8'(cursor_col) * 8'(CELL_PX);
            y_origin <= 7'(Y0) + 7'(cursor_row) * 7'(CELL_PX);
        end
    end

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Directed bench for sudoku_game_ctrl: expected draw requests are queued by the
// stimulus and checked by a monitor at each rising draw_req.
module tb_sudoku_game_ctrl;
  localparam int G = 4;

  logic       clock = 1'b0;
  logic       end_game;
  logic       start;
  logic       mode_go;
  logic [0:0] mode_sel;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       draw_done;
  logic       draw_req;
  logic [1:0] draw_kind;
  logic [0:0] grid_mode;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic [3:0] digit;
  logic [7:0] x_origin;
  logic [6:0] y_origin;
  logic       key_overrun;

  int checks = 0;
  int passed = 0;
  logic [29:0] exp_q[$];
  logic prev_req = 1'b0;

  sudoku_game_ctrl #(.GRID_N(G)) dut (
    .clock(clock), .end_game(end_game), .start(start), .mode_go(mode_go),
    .mode_sel(mode_sel), .scan_code(scan_code), .scan_valid(scan_valid),
    .draw_done(draw_done), .draw_req(draw_req), .draw_kind(draw_kind),
    .grid_mode(grid_mode), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .digit(digit), .x_origin(x_origin), .y_origin(y_origin),
    .key_overrun(key_overrun)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [29:0] pack(input logic [1:0] k, input logic [3:0] d,
                                       input logic [3:0] r, input logic [3:0] c,
                                       input logic [7:0] x, input logic [6:0] y,
                                       input logic [0:0] m);
    return {k, d, r, c, x, y, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [29:0] act;
    logic [29:0] e;
    if (draw_req && !prev_req) begin
      act = pack(draw_kind, digit, cursor_row, cursor_col, x_origin, y_origin, grid_mode);
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_req: got 0x%0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act === e) passed++;
        else $display("FAIL draw_req_fields @%0t: got 0x%0h expected 0x%0h", $time, act, e);
      end
    end
    prev_req = draw_req;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_key(input logic [7:0] code);
    @(posedge clock); #1;
    scan_code  = code;
    scan_valid = 1'b1;
    @(posedge clock); #1;
    scan_valid = 1'b0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!draw_req && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!draw_req) begin
      checks++;
      $display("FAIL req_timeout: got draw_req=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic pulse_done;
    @(posedge clock); #1;
    draw_done = 1'b1;
    @(posedge clock); #1;
    draw_done = 1'b0;
  endtask

  task automatic do_req;
    wait_req();
    pulse_done();
  endtask

  task automatic pulse_mode(input logic [0:0] sel);
    @(posedge clock); #1;
    mode_sel = sel;
    mode_go  = 1'b1;
    @(posedge clock); #1;
    mode_go  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     32'(draw_req),    32'd0);
    check({tag, "_kind"},    32'(draw_kind),   32'd0);
    check({tag, "_row"},     32'(cursor_row),  32'd0);
    check({tag, "_col"},     32'(cursor_col),  32'd0);
    check({tag, "_digit"},   32'(digit),       32'd0);
    check({tag, "_mode"},    32'(grid_mode),   32'd0);
    check({tag, "_x"},       32'(x_origin),    32'd0);
    check({tag, "_y"},       32'(y_origin),    32'd0);
    check({tag, "_overrun"}, 32'(key_overrun), 32'd0);
  endtask

  initial begin
    logic [3:0] ec;
    logic [7:0] ex;
    end_game = 1'b1; start = 1'b0; mode_go = 1'b0; mode_sel = 1'b0;
    scan_code = 8'h00; scan_valid = 1'b0; draw_done = 1'b0;
    tick(2);
    check_all_zero("reset");
    end_game = 1'b0;
    tick(1);

    // keys before the playfield exists are discarded silently
    send_key(8'h16);
    exp_q.push_back(pack(2'd0, 4'd0, 4'd0, 4'd0, 8'd0, 7'd0, 1'b0));
    start = 1'b1;
    wait_req();
    send_key(8'h1E);
    pulse_done();

    exp_q.push_back(pack(2'd1, 4'd0, 4'd0, 4'd0, 8'd0, 7'd0, 1'b1));
    pulse_mode(1'b1);
    do_req();
    exp_q.push_back(pack(2'd3, 4'd0, 4'd0, 4'd0, 8'd0, 7'd0, 1'b1));
    do_req();

    // cursor moves: right, right, down -> (1,2) at x=22, y=11
    exp_q.push_back(pack(2'd3, 4'd0, 4'd0, 4'd1, 8'd11, 7'd0, 1'b1));
    send_key(8'h74); do_req();
    exp_q.push_back(pack(2'd3, 4'd0, 4'd0, 4'd2, 8'd22, 7'd0, 1'b1));
    send_key(8'h74); do_req();
    exp_q.push_back(pack(2'd3, 4'd0, 4'd1, 4'd2, 8'd22, 7'd11, 1'b1));
    send_key(8'h72); do_req();

    exp_q.push_back(pack(2'd2, 4'd1, 4'd1, 4'd2, 8'd22, 7'd11, 1'b1));
    send_key(8'h16); do_req();

    // break code swallows 16, digit 5 exceeds a 4x4 grid, then clear cell
    send_key(8'hF0);
    send_key(8'h16);
    send_key(8'h2E);
    exp_q.push_back(pack(2'd2, 4'd0, 4'd1, 4'd2, 8'd22, 7'd11, 1'b1));
    send_key(8'h66); do_req();

    exp_q.push_back(pack(2'd3, 4'd0, 4'd1, 4'd1, 8'd11, 7'd11, 1'b1));
    send_key(8'h6B); do_req();
    exp_q.push_back(pack(2'd3, 4'd0, 4'd1, 4'd0, 8'd0, 7'd11, 1'b1));
    send_key(8'h6B); do_req();
`ifdef CURSOR_WRAP_EN
    ec = 4'd3; ex = 8'd33;
`else
    ec = 4'd0; ex = 8'd0;
`endif
    exp_q.push_back(pack(2'd3, 4'd0, 4'd1, ec, ex, 7'd11, 1'b1));
    send_key(8'h6B); do_req();
    check("overrun_clear", 32'(key_overrun), 32'd0);

    // buffering: up held during DIGIT_REQ, down dropped
    exp_q.push_back(pack(2'd2, 4'd2, 4'd1, ec, ex, 7'd11, 1'b1));
    send_key(8'h1E);
    wait_req();
    send_key(8'h75);
    send_key(8'h72);
    check("overrun_set", 32'(key_overrun), 32'd1);
    exp_q.push_back(pack(2'd3, 4'd2, 4'd0, ec, ex, 7'd0, 1'b1));
    pulse_done();
    do_req();
    check("overrun_sticky", 32'(key_overrun), 32'd1);

    // async reset in the middle of GRID_REQ
    start = 1'b0;
    end_game = 1'b1;
    tick(1);
    end_game = 1'b0;
    tick(1);
    exp_q.push_back(pack(2'd0, 4'd0, 4'd0, 4'd0, 8'd0, 7'd0, 1'b0));
    start = 1'b1;
    do_req();
    start = 1'b0;
    exp_q.push_back(pack(2'd1, 4'd0, 4'd0, 4'd0, 8'd0, 7'd0, 1'b1));
    pulse_mode(1'b1);
    wait_req();
    #2;
    end_game = 1'b1;
    #1;
    check_all_zero("midreq_reset");
    tick(1);
    end_game = 1'b0;
    pulse_done();
    tick(6);
    check("late_done_req", 32'(draw_req), 32'd0);
    check("late_done_kind", 32'(draw_kind), 32'd0);
    check("late_done_mode", 32'(grid_mode), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sudoku_game_ctrl.md
Name: sudoku_game_ctrl

Overview:
- Parametrised successor to the game control FSM.
- Sequences title page → difficulty selection → grid draw → play loop.
- Decodes PS/2 make/break scancodes internally; tracks an N×N cursor; computes cell pixel origins.
- Issues one-outstanding draw requests to the VGA datapath with a req/done handshake. Sits between the PS/2 receiver and the drawing datapath.

Parameters:
- GRID_N, 9, cells per row/column (2..15).
- CELL_PX, 11, pixel pitch of one cell.
- X0, 0, x pixel of cell (0,0).
- Y0, 0, y pixel of cell (0,0).
- NUM_MODES, 2, number of difficulty modes (grids).
- MODE_W, 1, width of the mode index.
- RC_W, 4, width of the row/column counters.

Ports:
- clock  in  1  system clock, rising edge.
- end_game  in  1  asynchronous active-high reset.
- start  in  1  level; leave IDLE.
- mode_go  in  1  one-cycle strobe; accept mode_sel.
- mode_sel  in  MODE_W  requested difficulty mode.
- scan_code  in  8  PS/2 byte.
- scan_valid  in  1  one-cycle strobe qualifying scan_code.
- draw_done  in  1  datapath finished current request.
- draw_req  out  1  request pending.
- draw_kind  out  2  0 page, 1 grid, 2 digit, 3 cursor.
- grid_mode  out  MODE_W  latched mode.
- cursor_row  out  RC_W  current row.
- cursor_col  out  RC_W  current column.
- digit  out  4  value to draw; 0 = clear cell.
- x_origin  out  8  X0 + cursor_col*CELL_PX, truncated to 8 bits.
- y_origin  out  7  Y0 + cursor_row*CELL_PX, truncated to 7 bits.
- key_overrun  out  1  sticky: a key was dropped.

Behaviour:
- Reset (end_game high, async):
  - State = IDLE.
  - All outputs 0: cursor 0,0; digit 0; grid_mode 0; overrun 0; break/pending flags clear.
  - Reset mid-request abandons it; a draw_done arriving after reset is ignored.
- States:
  - IDLE → PAGE_REQ when start = 1.
  - PAGE_REQ: draw_req = 1, kind = 0; held until draw_done → SELECT.
  - SELECT: on mode_go with mode_sel < NUM_MODES, latch grid_mode → GRID_REQ. Out-of-range mode_sel is ignored.
  - GRID_REQ: kind = 1 → CURSOR_REQ on draw_done.
  - CURSOR_REQ: kind = 3 → PLAY on draw_done.
  - PLAY: acts on decoded key events.
    - Digit → DIGIT_REQ.
    - Arrow → update cursor, then CURSOR_REQ.
    - Other keys → stay in PLAY.
  - DIGIT_REQ: kind = 2, digit held → PLAY on draw_done.
- Handshake:
  - draw_req goes high the cycle after entering a REQ state.
  - draw_req stays high until the cycle draw_done is sampled 1, then falls.
  - kind, digit, origin and cursor are stable while draw_req = 1.
  - draw_done while draw_req = 0 is ignored.
- Scancode decode (every cycle, independent of state):
  - 0xE0: prefix, ignored.
  - 0xF0: sets break flag; the next valid byte clears the flag and produces no event.
  - Make codes:
    - 16/1E/26/25/2E/36/3D/3E/46 → digits 1..9.
    - 45 or 66 → clear (digit 0).
    - 75 up, 72 down, 6B left, 74 right.
  - Digits greater than GRID_N are discarded.
- Key buffering:
  - An event arriving outside PLAY (after CURSOR_REQ first completes) goes into a one-deep pending slot.
  - The pending event is consumed on the first PLAY cycle.
  - If the slot is full, the new event is dropped and key_overrun is set until reset.
  - Events before the first entry to PLAY are discarded without setting overrun.
- Cursor:
  - Clamped to 0..GRID_N-1 (see optional feature).
  - Origin is registered and updates the cycle after the cursor changes, i.e. before draw_req rises.
- Simultaneous events:
  - scan_valid and draw_done in the same cycle: both are honoured.
  - start held high after IDLE has no effect.

Optional Feature:
- CURSOR_WRAP_EN defined: moves past an edge wrap around.
  - Left from col 0 → col GRID_N-1; right from col GRID_N-1 → col 0; same for rows.
- CURSOR_WRAP_EN undefined: the cursor saturates at the edge. CURSOR_REQ is still issued (redraws the same cell).

Test Plan:
- Reset + start: start = 1 → draw_req = 1, kind = 0. draw_done → SELECT; mode_go with sel = 1 → kind = 1, grid_mode = 1. draw_done → kind = 3, origin (0,0).
- In PLAY, key 0x74 ×2 then 0x72 → cursor (1,2); x_origin = 22, y_origin = 11 (defaults).
- Key 0x16 → kind = 2, digit = 1. Sequence F0,16 → no event. With GRID_N = 4, key 0x2E (5) → discarded.
- Edges: key 0x6B at col 0 → col stays 0 (wrap off) or becomes 8 (CURSOR_WRAP_EN).
- Buffering: during DIGIT_REQ send 0x75 then 0x72 → up executed after done, down dropped, key_overrun = 1.
- Async reset asserted mid-GRID_REQ → all outputs 0 immediately; a later draw_done is ignored; state IDLE.
